alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 33 +++
 rtl/alu_regfile.sv | 44 ++++
 rtl/alu_issue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
// Shared constants for the ALU issue stage: operand/address widths, the
// 4-bit ALU operation encodings, and a helper that recognises legal opcodes.
// ---------------------------------------------------------------------------
package alu_issue_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [OP_W-1:0] ALUOP_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALUOP_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALUOP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALUOP_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALUOP_LET = 4'b0111;
    localparam logic [OP_W-1:0] ALUOP_LSR = 4'b1000;
    localparam logic [OP_W-1:0] ALUOP_LSL = 4'b1001;
    localparam logic [OP_W-1:0] ALUOP_ASR = 4'b1010;
    localparam logic [OP_W-1:0] ALUOP_XOR = 4'b1101;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_LET,
            ALUOP_LSR, ALUOP_LSL, ALUOP_ASR, ALUOP_XOR: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// 32 x 32-bit register file, two asynchronous read ports and one synchronous
// write port. x0 always reads zero and ignores writes. All entries clear on
// asynchronous active-low reset.
//
// Ports:
//   clk, rst_n             clock / async active-low reset
//   i_raddr1 / o_rdata1    read port 1
//   i_raddr2 / o_rdata2    read port 2
//   i_we, i_waddr, i_wdata write port (rising edge)
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [REG_AW-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
    end

endmodule

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
// Operand-fetch / issue stage in front of an ALU. Accepts a decoded
// instruction, reads its operands from the register file and presents them
// in a single output register with a valid/ready handshake (1-cycle latency,
// full throughput). Illegal opcodes are issued as AND and latch op_err.
//
// Build option: define OPERAND_BYPASS_EN to forward a same-cycle writeback
// into the captured operands; otherwise the pre-write register value is used.
//
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   in_valid, in_ready             upstream handshake
//   rs1, rs2, rd, in_alu_op        instruction fields
//   use_imm, imm                   immediate select and value for op2
//   wb_en, wb_addr, wb_data        register-file write port
//   out_valid, out_ready           downstream handshake
//   op1, op2, alu_op, out_rd       registered issue payload
//   op_err                         sticky illegal-opcode flag
//   issue_cnt                      count of completed output transfers
// ---------------------------------------------------------------------------
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [OP_W-1:0]   in_alu_op,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic [OP_W-1:0]   alu_op,
    output logic [REG_AW-1:0] out_rd,
    output logic              op_err,
    output logic [15:0]       issue_cnt
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [OP_W-1:0]   r_alu_op;
    logic [REG_AW-1:0] r_out_rd;
    logic              r_op_err;
    logic [15:0]       r_issue_cnt;

    logic [DATA_W-1:0] w_rf_rdata1;
    logic [DATA_W-1:0] w_rf_rdata2;
    logic [DATA_W-1:0] w_op1_d;
    logic [DATA_W-1:0] w_rs2_val;
    logic [DATA_W-1:0] w_op2_d;
    logic [OP_W-1:0]   w_alu_op_d;
    logic              w_op_legal;
    logic              w_accept;
    logic              w_xfer;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raddr1 (rs1),
        .o_rdata1 (w_rf_rdata1),
        .i_raddr2 (rs2),
        .o_rdata2 (w_rf_rdata2),
        .i_we     (wb_en),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data)
    );

    // Ready whenever the output register is empty or being drained this cycle.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    always_comb begin
`ifdef OPERAND_BYPASS_EN
        // x0 is never forwarded: it must still read as zero.
        w_op1_d   = (wb_en && (wb_addr == rs1) && (rs1 != '0)) ? wb_data : w_rf_rdata1;
        w_rs2_val = (wb_en && (wb_addr == rs2) && (rs2 != '0)) ? wb_data : w_rf_rdata2;
`else
        w_op1_d   = w_rf_rdata1;
        w_rs2_val = w_rf_rdata2;
`endif
        w_op2_d    = use_imm ? imm : w_rs2_val;
        w_op_legal = is_legal_op(in_alu_op);
        w_alu_op_d = w_op_legal ? in_alu_op : ALUOP_AND;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Payload only moves on accept, so it holds through stalls and drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_alu_op <= '0;
            r_out_rd <= '0;
        end else if (w_accept) begin
            r_op1    <= w_op1_d;
            r_op2    <= w_op2_d;
            r_alu_op <= w_alu_op_d;
            r_out_rd <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_err <= 1'b0;
        end else if (w_accept && !w_op_legal) begin
            r_op_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
        end else if (w_xfer) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign op1       = r_op1;
    assign op2       = r_op2;
    assign alu_op    = r_alu_op;
    assign out_rd    = r_out_rd;
    assign op_err    = r_op_err;
    assign issue_cnt = r_issue_cnt;

endmodule
